// File: rtl/flght_pkg.sv
// Shared types, defaults and saturation helper for the PID flight controller.
package flght_pkg;

  typedef enum logic [1:0] {
    AX_PTCH = 2'd0,
    AX_ROLL = 2'd1,
    AX_YAW  = 2'd2
  } axis_t;

  typedef enum logic [2:0] {
    IDLE,
    CALC_P,
    CALC_R,
    CALC_Y,
    MIX
  } state_t;

  localparam int          NUM_AXES          = 3;
  localparam logic [10:0] CAL_SPEED_DEF     = 11'h1B0;
  localparam int          MIN_RUN_SPEED_DEF = 512;

  // Clamp a signed value into the range of an out_width-bit two's complement word.
  function automatic int sat_s(input int value, input int out_width);
    int hi;
    int lo;
    hi = (1 << (out_width - 1)) - 1;
    lo = -(1 << (out_width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/flght_d_queue.sv
// Error history for the D term: shifts in one sample per enable, exposes the oldest.
module flght_d_queue #(
  parameter int DEPTH = 14,
  parameter int ERR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_en,
  input  logic signed [ERR_W-1:0] din,
  output logic signed [ERR_W-1:0] tail
);

  logic signed [ERR_W-1:0] q_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
    end else if (shift_en) begin
      q_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) q_reg[i] <= q_reg[i-1];
    end
  end

  assign tail = q_reg[DEPTH-1];

endmodule

// File: rtl/flght_cntrl_pid.sv
// PID attitude controller: one shared P/I/D datapath time-multiplexed over
// pitch, roll and yaw, followed by a quad motor mixer with output clamping.
module flght_cntrl_pid
  import flght_pkg::*;
#(
  parameter int             D_QUEUE_DEPTH = 14,
  parameter int             ERR_W         = 10,
  parameter int             DDIFF_W       = 6,
  parameter int             SPD_W         = 11,
  parameter int             P_NUM         = 5,
  parameter int             P_SHIFT       = 3,
  parameter int             D_COEFF       = 7,
  parameter int             I_W           = 14,
  parameter int             I_LIM         = 8191,
  parameter int             I_SHIFT       = 6,
  parameter logic [SPD_W-1:0] CAL_SPEED   = SPD_W'(CAL_SPEED_DEF),
  parameter int             MIN_RUN_SPEED = MIN_RUN_SPEED_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic               inertial_cal,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic [8:0]         thrst,
  output logic [SPD_W-1:0]   frnt_spd,
  output logic [SPD_W-1:0]   bck_spd,
  output logic [SPD_W-1:0]   lft_spd,
  output logic [SPD_W-1:0]   rght_spd,
  output logic               spd_vld,
  output logic               busy
);

  localparam int SUM_W   = SPD_W + 3;
  localparam int SPD_MAX = (1 << SPD_W) - 1;

  state_t state_reg, state_next;
  logic   capture_en, calc_en, mix_en;
  axis_t  cur_axis;

  logic signed [15:0] des_hold_reg [NUM_AXES];
  logic signed [15:0] act_hold_reg [NUM_AXES];
  logic [8:0]         thrst_hold_reg;
  logic               cal_hold_reg;

  logic signed [ERR_W-1:0] err_sat;
  logic signed [ERR_W-1:0] tail_arr  [NUM_AXES];
  logic signed [I_W-1:0]   integ_arr [NUM_AXES];
  logic signed [SUM_W-1:0] x_all_arr [NUM_AXES];
  logic                    integ_clr;

  int err_i, err_sat_i, ddiff_i, pterm_i, dterm_i;
  int integ_sum_i, integ_next_i, iterm_i, x_all_i;
  int base_i, p_i, r_i, y_i;

  logic signed [SUM_W-1:0] frnt_sum, bck_sum, lft_sum, rght_sum;
  logic [SPD_W-1:0]        frnt_reg, bck_reg, lft_reg, rght_reg;
  logic                    spd_vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // vld is only looked at in IDLE, so strobes arriving mid-calculation vanish.
  always_comb begin
    state_next = state_reg;
    capture_en = 1'b0;
    calc_en    = 1'b0;
    mix_en     = 1'b0;
    cur_axis   = AX_PTCH;
    case (state_reg)
      IDLE: begin
        if (vld) begin
          capture_en = 1'b1;
          state_next = CALC_P;
        end
      end
      CALC_P: begin
        calc_en    = 1'b1;
        cur_axis   = AX_PTCH;
        state_next = CALC_R;
      end
      CALC_R: begin
        calc_en    = 1'b1;
        cur_axis   = AX_ROLL;
        state_next = CALC_Y;
      end
      CALC_Y: begin
        calc_en    = 1'b1;
        cur_axis   = AX_YAW;
        state_next = MIX;
      end
      MIX: begin
        mix_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        des_hold_reg[i] <= '0;
        act_hold_reg[i] <= '0;
      end
      thrst_hold_reg <= '0;
      cal_hold_reg   <= 1'b0;
    end else if (capture_en) begin
      des_hold_reg[AX_PTCH] <= d_ptch;
      des_hold_reg[AX_ROLL] <= d_roll;
      des_hold_reg[AX_YAW]  <= d_yaw;
      act_hold_reg[AX_PTCH] <= ptch;
      act_hold_reg[AX_ROLL] <= roll;
      act_hold_reg[AX_YAW]  <= yaw;
      thrst_hold_reg        <= thrst;
      cal_hold_reg          <= inertial_cal;
    end
  end

  assign integ_clr = (thrst_hold_reg == '0) || cal_hold_reg;

  // Shared datapath for whichever axis the FSM has selected this cycle.
  always_comb begin
    err_i     = int'(act_hold_reg[cur_axis]) - int'(des_hold_reg[cur_axis]);
    err_sat_i = sat_s(err_i, ERR_W);
    ddiff_i   = sat_s(err_sat_i - int'(tail_arr[cur_axis]), DDIFF_W);
    dterm_i   = D_COEFF * ddiff_i;
    pterm_i   = (err_sat_i * P_NUM) >>> P_SHIFT;
    integ_sum_i = int'(integ_arr[cur_axis]) + err_sat_i;
    if (integ_clr)                integ_next_i = 0;
    else if (integ_sum_i > I_LIM) integ_next_i = I_LIM;
    else if (integ_sum_i < -I_LIM) integ_next_i = -I_LIM;
    else                          integ_next_i = integ_sum_i;
    iterm_i = integ_next_i >>> I_SHIFT;
    x_all_i = pterm_i + dterm_i + iterm_i;
  end

  assign err_sat = ERR_W'(err_sat_i);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      logic                    sel;
      logic signed [I_W-1:0]   integ_reg;
      logic signed [SUM_W-1:0] x_all_reg;

      assign sel = calc_en && (int'(cur_axis) == gi);

      flght_d_queue #(
        .DEPTH (D_QUEUE_DEPTH),
        .ERR_W (ERR_W)
      ) u_d_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (sel),
        .din      (err_sat),
        .tail     (tail_arr[gi])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          integ_reg <= '0;
          x_all_reg <= '0;
        end else if (sel) begin
          integ_reg <= I_W'(integ_next_i);
          x_all_reg <= SUM_W'(x_all_i);
        end
      end

      assign integ_arr[gi] = integ_reg;
      assign x_all_arr[gi] = x_all_reg;
    end
  endgenerate

  always_comb begin
    base_i   = MIN_RUN_SPEED + int'(thrst_hold_reg);
    p_i      = int'(x_all_arr[AX_PTCH]);
    r_i      = int'(x_all_arr[AX_ROLL]);
    y_i      = int'(x_all_arr[AX_YAW]);
    frnt_sum = SUM_W'(base_i - p_i - y_i);
    bck_sum  = SUM_W'(base_i + p_i - y_i);
    lft_sum  = SUM_W'(base_i - r_i + y_i);
    rght_sum = SUM_W'(base_i + r_i + y_i);
  end

  function automatic logic [SPD_W-1:0] spd_clip(input logic signed [SUM_W-1:0] s);
    if (s < 0) return '0;
    else if (int'(s) > SPD_MAX) return SPD_W'(SPD_MAX);
    else return s[SPD_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frnt_reg    <= '0;
      bck_reg     <= '0;
      lft_reg     <= '0;
      rght_reg    <= '0;
      spd_vld_reg <= 1'b0;
    end else begin
      spd_vld_reg <= mix_en;
      if (mix_en) begin
        frnt_reg <= spd_clip(frnt_sum);
        bck_reg  <= spd_clip(bck_sum);
        lft_reg  <= spd_clip(lft_sum);
        rght_reg <= spd_clip(rght_sum);
      end
    end
  end

  // Calibration speed bypasses the registers so the ESCs see it immediately.
  assign frnt_spd = inertial_cal ? CAL_SPEED : frnt_reg;
  assign bck_spd  = inertial_cal ? CAL_SPEED : bck_reg;
  assign lft_spd  = inertial_cal ? CAL_SPEED : lft_reg;
  assign rght_spd = inertial_cal ? CAL_SPEED : rght_reg;
  assign spd_vld  = spd_vld_reg;
  assign busy     = (state_reg != IDLE);

endmodule
